// File: rtl/rv32_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rv32_ctrl_pkg
// Shared definitions for the multicycle RV32I control unit: opcode and
// branch funct3 values, FSM state type, ALU operation encoding, datapath mux
// select encodings, trap causes, and the funct3/funct7 ALU decode helper.
// ---------------------------------------------------------------------------
package rv32_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JALR_ADR, S_JAL,
    S_LUI, S_AUIPC, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_op_t;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] RES_ALU_OUT = 2'b00;
  localparam logic [1:0] RES_MEM     = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;
  localparam logic [1:0] SRC_A_ZERO   = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Immediate-form ALU ops reuse bit 30 as part of the immediate, so only
  // R-type may turn ADD into SUB; shifts always honour bit 30 for SRA.
  function automatic alu_op_t alu_decode(input logic [2:0] funct3,
                                         input logic       funct7_b5,
                                         input logic       is_rtype);
    alu_decode = ALU_ADD;
    case (funct3)
      3'b000: if (is_rtype && funct7_b5) alu_decode = ALU_SUB;
      3'b001: alu_decode = ALU_SLL;
      3'b010: alu_decode = ALU_SLT;
      3'b011: alu_decode = ALU_SLTU;
      3'b100: alu_decode = ALU_XOR;
      3'b101: alu_decode = funct7_b5 ? ALU_SRA : ALU_SRL;
      3'b110: alu_decode = ALU_OR;
      3'b111: alu_decode = ALU_AND;
      default: alu_decode = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_branch_eval.sv
// ---------------------------------------------------------------------------
// mc_branch_eval
// Resolves whether a conditional branch is taken from its funct3 and the
// datapath comparator flags, and flags the two funct3 values that are not
// valid branch conditions.
//   funct3             in  3  branch condition select
//   equal              in  1  rs1 == rs2
//   less_than          in  1  signed rs1 < rs2
//   less_than_unsigned in  1  unsigned rs1 < rs2
//   branch_correct     out 1  branch is taken
//   illegal            out 1  funct3 is 010 or 011
// ---------------------------------------------------------------------------
module mc_branch_eval
  import rv32_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       equal,
  input  logic       less_than,
  input  logic       less_than_unsigned,
  output logic       branch_correct,
  output logic       illegal
);

  // Each condition is one comparator flag, possibly inverted.
  always_comb begin
    branch_correct = 1'b0;
    illegal        = 1'b0;
    case (funct3)
      F3_BEQ:  branch_correct = equal;
      F3_BNE:  branch_correct = !equal;
      F3_BLT:  branch_correct = less_than;
      F3_BGE:  branch_correct = !less_than;
      F3_BLTU: branch_correct = less_than_unsigned;
      F3_BGEU: branch_correct = !less_than_unsigned;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_decoder.sv
// ---------------------------------------------------------------------------
// multicycle_decoder
// Moore-style control FSM for a multicycle RV32I datapath sharing one ALU and
// one memory port. Sequences fetch/decode/execute/writeback, handshakes with
// variable-latency memory, traps illegal opcodes and memory timeouts.
//   clk, reset           clock and asynchronous active-high reset
//   instruction          IR contents (valid from DECODE onward)
//   equal/less_than/less_than_unsigned  datapath comparator flags
//   mem_ready            memory completes the current request
//   mem_req/mem_write/mem_width/adr_src  memory request controls
//   ir_write/pc_write/reg_write          register enables
//   result_src/alu_src_a/alu_src_b/alu_control/immediate_control  datapath
//   instr_retired        one-cycle pulse per completed instruction
//   trap/trap_cause      sticky trap indication and reason
// ---------------------------------------------------------------------------
module multicycle_decoder
  import rv32_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = 16,
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter int TO_W            = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        equal,
  input  logic        less_than,
  input  logic        less_than_unsigned,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic [2:0]  mem_width,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_control,
  output logic [2:0]  immediate_control,
  output logic        instr_retired,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  state_t            state;
  state_t            next_state;
  logic [TO_W-1:0]   watchdog;
  logic [1:0]        next_cause;
  logic              timeout;
  logic              decode_illegal;
  logic              branch_correct;
  logic              branch_illegal;
  logic              pc_write_reg;
  logic              retire_reg;

  logic              nxt_mem_req, nxt_mem_write, nxt_adr_src, nxt_reg_write;
  logic              nxt_pc_write, nxt_retire, nxt_trap;
  logic [2:0]        nxt_mem_width, nxt_imm;
  logic [1:0]        nxt_result_src, nxt_src_a, nxt_src_b;
  logic [3:0]        nxt_alu;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       unused_instr_bits;

  assign opcode    = instruction[6:0];
  assign funct3    = instruction[14:12];
  assign funct7_b5 = instruction[30];
  assign unused_instr_bits = ^{instruction[31], instruction[29:15], instruction[11:7]};

  mc_branch_eval u_branch_eval (
    .funct3             (funct3),
    .equal              (equal),
    .less_than          (less_than),
    .less_than_unsigned (less_than_unsigned),
    .branch_correct     (branch_correct),
    .illegal            (branch_illegal)
  );

  // The watchdog fires on the last allowed waiting cycle; a simultaneous
  // mem_ready is a completion, so it suppresses the timeout.
  assign timeout = (TIMEOUT_CYCLES != 0) && mem_req && !mem_ready &&
                   (watchdog == TO_W'(TIMEOUT_CYCLES - 1));

  // Opcodes outside RV32I, plus branches with a reserved funct3, are illegal.
  always_comb begin
    case (opcode)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: decode_illegal = 1'b0;
      OP_BRANCH:                         decode_illegal = branch_illegal;
      default:                           decode_illegal = 1'b1;
    endcase
  end

  // Next-state logic. Memory states only advance when a request is actually
  // being presented, so a stray mem_ready right after reset is ignored.
  always_comb begin
    next_state = state;
    next_cause = trap_cause;
    case (state)
      S_FETCH: begin
        if (mem_req && mem_ready) next_state = S_DECODE;
        else if (timeout) begin
          next_state = S_TRAP;
          next_cause = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (decode_illegal) begin
          if (TRAP_ON_ILLEGAL) begin
            next_state = S_TRAP;
            next_cause = CAUSE_ILLEGAL;
          end else begin
            next_state = S_FETCH;
          end
        end else begin
          case (opcode)
            OP_LOAD, OP_STORE: next_state = S_MEM_ADR;
            OP_RTYPE:          next_state = S_EXEC_R;
            OP_ITYPE:          next_state = S_EXEC_I;
            OP_BRANCH:         next_state = S_BRANCH;
            OP_JAL:            next_state = S_JAL;
            OP_JALR:           next_state = S_JALR_ADR;
            OP_LUI:            next_state = S_LUI;
            OP_AUIPC:          next_state = S_AUIPC;
            default:           next_state = S_FETCH;
          endcase
        end
      end
      S_MEM_ADR:  next_state = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ, S_MEM_WRITE: begin
        if (mem_req && mem_ready) next_state = (state == S_MEM_READ) ? S_MEM_WB : S_FETCH;
        else if (timeout) begin
          next_state = S_TRAP;
          next_cause = CAUSE_TIMEOUT;
        end
      end
      S_MEM_WB, S_ALU_WB, S_BRANCH:       next_state = S_FETCH;
      S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC: next_state = S_ALU_WB;
      S_JALR_ADR:                         next_state = S_JAL;
      S_JAL:                              next_state = S_ALU_WB;
      S_TRAP:                             next_state = S_TRAP;
      default:                            next_state = S_FETCH;
    endcase
  end

  // Output values for the state being entered; registering them makes every
  // strobe line up with its state and keeps them glitch-free.
  always_comb begin
    nxt_mem_req    = 1'b0;
    nxt_mem_write  = 1'b0;
    nxt_mem_width  = 3'b000;
    nxt_adr_src    = 1'b0;
    nxt_reg_write  = 1'b0;
    nxt_pc_write   = 1'b0;
    nxt_retire     = 1'b0;
    nxt_trap       = 1'b0;
    nxt_result_src = RES_ALU_OUT;
    nxt_src_a      = SRC_A_PC;
    nxt_src_b      = SRC_B_RS2;
    nxt_alu        = ALU_ADD;
    nxt_imm        = IMM_I;
    case (next_state)
      S_FETCH: begin
        nxt_mem_req    = 1'b1;
        nxt_src_b      = SRC_B_FOUR;
        nxt_result_src = RES_ALU;
      end
      S_DECODE: begin
        nxt_src_a = SRC_A_OLD_PC;
        nxt_src_b = SRC_B_IMM;
        nxt_imm   = IMM_B;
      end
      S_MEM_ADR: begin
        nxt_src_a = SRC_A_RS1;
        nxt_src_b = SRC_B_IMM;
        nxt_imm   = (opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEM_READ: begin
        nxt_mem_req   = 1'b1;
        nxt_adr_src   = 1'b1;
        nxt_mem_width = funct3;
      end
      S_MEM_WRITE: begin
        nxt_mem_req   = 1'b1;
        nxt_mem_write = 1'b1;
        nxt_adr_src   = 1'b1;
        nxt_mem_width = funct3;
      end
      S_MEM_WB: begin
        nxt_result_src = RES_MEM;
        nxt_reg_write  = 1'b1;
        nxt_retire     = 1'b1;
      end
      S_EXEC_R: begin
        nxt_src_a = SRC_A_RS1;
        nxt_alu   = alu_decode(funct3, funct7_b5, 1'b1);
      end
      S_EXEC_I: begin
        nxt_src_a = SRC_A_RS1;
        nxt_src_b = SRC_B_IMM;
        nxt_alu   = alu_decode(funct3, funct7_b5, 1'b0);
      end
      S_ALU_WB: begin
        nxt_reg_write = 1'b1;
        nxt_retire    = 1'b1;
      end
      S_BRANCH: begin
        nxt_pc_write = branch_correct;
        nxt_retire   = 1'b1;
      end
      S_JALR_ADR: begin
        nxt_src_a = SRC_A_RS1;
        nxt_src_b = SRC_B_IMM;
      end
      S_JAL: begin
        nxt_src_a    = SRC_A_OLD_PC;
        nxt_src_b    = SRC_B_FOUR;
        nxt_pc_write = 1'b1;
      end
      S_LUI: begin
        nxt_src_a = SRC_A_ZERO;
        nxt_src_b = SRC_B_IMM;
        nxt_imm   = IMM_U;
      end
      S_AUIPC: begin
        nxt_src_a = SRC_A_OLD_PC;
        nxt_src_b = SRC_B_IMM;
        nxt_imm   = IMM_U;
      end
      S_TRAP:  nxt_trap = 1'b1;
      default: nxt_trap = 1'b0;
    endcase
  end

  // State, watchdog and registered strobes. Reset clears all strobes, so
  // the first FETCH cycle after release presents no request yet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= S_FETCH;
      watchdog          <= '0;
      trap_cause        <= CAUSE_NONE;
      mem_req           <= 1'b0;
      mem_write         <= 1'b0;
      mem_width         <= 3'b000;
      adr_src           <= 1'b0;
      reg_write         <= 1'b0;
      pc_write_reg      <= 1'b0;
      retire_reg        <= 1'b0;
      trap              <= 1'b0;
      result_src        <= RES_ALU_OUT;
      alu_src_a         <= SRC_A_PC;
      alu_src_b         <= SRC_B_RS2;
      alu_control       <= ALU_ADD;
      immediate_control <= IMM_I;
    end else begin
      state             <= next_state;
      watchdog          <= (mem_req && !mem_ready && !timeout) ? watchdog + TO_W'(1) : '0;
      trap_cause        <= next_cause;
      mem_req           <= nxt_mem_req;
      mem_write         <= nxt_mem_write;
      mem_width         <= nxt_mem_width;
      adr_src           <= nxt_adr_src;
      reg_write         <= nxt_reg_write;
      pc_write_reg      <= nxt_pc_write;
      retire_reg        <= nxt_retire;
      trap              <= nxt_trap;
      result_src        <= nxt_result_src;
      alu_src_a         <= nxt_src_a;
      alu_src_b         <= nxt_src_b;
      alu_control       <= nxt_alu;
      immediate_control <= nxt_imm;
    end
  end

  // Strobes tied to a memory completion must fire in the completing cycle,
  // so they combine the registered request with the live mem_ready.
  assign ir_write      = (state == S_FETCH) && mem_req && mem_ready;
  assign pc_write      = pc_write_reg || ir_write;
  assign instr_retired = retire_reg ||
                         ((state == S_MEM_WRITE) && mem_req && mem_ready) ||
                         ((state == S_DECODE) && decode_illegal && !TRAP_ON_ILLEGAL);

endmodule

// File: tb/tb_multicycle_decoder.sv
// ---------------------------------------------------------------------------
// tb_multicycle_decoder
// Directed bench for multicycle_decoder. A trapping instance and a
// NOP-on-illegal instance share every input.
// ---------------------------------------------------------------------------
module tb_multicycle_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = 32'h0;
  logic        equal = 1'b0, less_than = 1'b0, less_than_unsigned = 1'b0;
  logic        mem_ready = 1'b0;

  logic mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, instr_retired, trap;
  logic [2:0] mem_width, immediate_control;
  logic [1:0] result_src, alu_src_a, alu_src_b, trap_cause;
  logic [3:0] alu_control;

  logic mem_req_n, mem_write_n, adr_src_n, ir_write_n, pc_write_n, reg_write_n, instr_retired_n, trap_n;
  logic [2:0] mem_width_n, immediate_control_n;
  logic [1:0] result_src_n, alu_src_a_n, alu_src_b_n, trap_cause_n;
  logic [3:0] alu_control_n;

  int total = 0;
  int bad = 0;

  multicycle_decoder #(.TIMEOUT_CYCLES(16), .TRAP_ON_ILLEGAL(1'b1), .TO_W(5)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .equal(equal),
    .less_than(less_than), .less_than_unsigned(less_than_unsigned), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .mem_width(mem_width), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .immediate_control(immediate_control), .instr_retired(instr_retired),
    .trap(trap), .trap_cause(trap_cause)
  );

  multicycle_decoder #(.TIMEOUT_CYCLES(16), .TRAP_ON_ILLEGAL(1'b0), .TO_W(5)) dut_nop (
    .clk(clk), .reset(reset), .instruction(instruction), .equal(equal),
    .less_than(less_than), .less_than_unsigned(less_than_unsigned), .mem_ready(mem_ready),
    .mem_req(mem_req_n), .mem_write(mem_write_n), .mem_width(mem_width_n), .adr_src(adr_src_n),
    .ir_write(ir_write_n), .pc_write(pc_write_n), .reg_write(reg_write_n), .result_src(result_src_n),
    .alu_src_a(alu_src_a_n), .alu_src_b(alu_src_b_n), .alu_control(alu_control_n),
    .immediate_control(immediate_control_n), .instr_retired(instr_retired_n),
    .trap(trap_n), .trap_cause(trap_cause_n)
  );

  always #5 clk = ~clk;

  // Advance one cycle and settle just past the active edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full reset; returns in FETCH with the request presented.
  task automatic do_reset;
    reset = 1'b1;
    mem_ready = 1'b0;
    equal = 1'b0; less_than = 1'b0; less_than_unsigned = 1'b0;
    instruction = 32'h0;
    tick; tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    mem_ready = 1'b1;
    tick;
    total++;
    if ({mem_req, mem_write, ir_write, pc_write, reg_write, instr_retired, trap, adr_src} !== 8'b0) begin
      bad++; $display("[TB] FAIL reset_strobes: got %b want 00000000",
        {mem_req, mem_write, ir_write, pc_write, reg_write, instr_retired, trap, adr_src});
    end
    total++;
    if (trap_cause !== 2'b00) begin bad++; $display("[TB] FAIL reset_cause: got %b want 00", trap_cause); end
    reset = 1'b0;
    #1;
    total++;
    if ({mem_req, ir_write, pc_write} !== 3'b000) begin
      bad++; $display("[TB] FAIL post_reset_strobes: got %b want 000", {mem_req, ir_write, pc_write});
    end
    mem_ready = 1'b0;
    tick;
    total++;
    if ({mem_req, adr_src, alu_src_a, alu_src_b, result_src, mem_width, alu_control} !== {1'b1, 1'b0, 2'b00, 2'b10, 2'b10, 3'b000, 4'b0000}) begin
      bad++; $display("[TB] FAIL fetch_controls: got %b want 10001010000000",
        {mem_req, adr_src, alu_src_a, alu_src_b, result_src, mem_width, alu_control});
    end
  endtask

  task automatic test_alu_ops;
    logic [31:0] tbl_instr [8] = '{32'h002081B3, 32'h402081B3, 32'h0020C1B3, 32'h4020D1B3,
                                   32'h0020B1B3, 32'hC0000093, 32'h4030D093, 32'h0050F093};
    logic [3:0]  tbl_alu   [8] = '{4'b0000, 4'b0001, 4'b0100, 4'b1001,
                                   4'b0110, 4'b0000, 4'b1001, 4'b0010};
    logic [1:0]  tbl_b     [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
    for (int i = 0; i < 8; i++) begin
      instruction = tbl_instr[i];
      mem_ready = 1'b1;
      #1;
      total++;
      if ({ir_write, pc_write, instr_retired} !== 3'b110) begin
        bad++; $display("[TB] FAIL alu%0d_fetch: got %b want 110", i, {ir_write, pc_write, instr_retired});
      end
      tick;
      total++;
      if ({alu_src_a, alu_src_b, immediate_control, ir_write, mem_req} !== {2'b01, 2'b01, 3'b010, 1'b0, 1'b0}) begin
        bad++; $display("[TB] FAIL alu%0d_decode: got %b want 010101000",
          i, {alu_src_a, alu_src_b, immediate_control, ir_write, mem_req});
      end
      tick;
      total++;
      if (alu_control !== tbl_alu[i]) begin
        bad++; $display("[TB] FAIL alu%0d_op: got %b want %b", i, alu_control, tbl_alu[i]);
      end
      total++;
      if ({alu_src_a, alu_src_b, instr_retired, reg_write} !== {2'b10, tbl_b[i], 1'b0, 1'b0}) begin
        bad++; $display("[TB] FAIL alu%0d_exec: got %b want %b",
          i, {alu_src_a, alu_src_b, instr_retired, reg_write}, {2'b10, tbl_b[i], 2'b00});
      end
      if (tbl_b[i] == 2'b01) begin
        total++;
        if (immediate_control !== 3'b000) begin
          bad++; $display("[TB] FAIL alu%0d_imm: got %b want 000", i, immediate_control);
        end
      end
      tick;
      total++;
      if ({reg_write, instr_retired, result_src} !== 4'b1100) begin
        bad++; $display("[TB] FAIL alu%0d_wb: got %b want 1100", i, {reg_write, instr_retired, result_src});
      end
      mem_ready = 1'b0;
      tick;
      total++;
      if ({mem_req, instr_retired, reg_write} !== 3'b100) begin
        bad++; $display("[TB] FAIL alu%0d_refetch: got %b want 100", i, {mem_req, instr_retired, reg_write});
      end
    end
  endtask

  task automatic test_load;
    int pulses = 0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({mem_req, ir_write, adr_src} !== 3'b100) begin
        bad++; $display("[TB] FAIL lw_fetch_wait%0d: got %b want 100", i, {mem_req, ir_write, adr_src});
      end
      tick;
    end
    instruction = 32'h0080A283;
    mem_ready = 1'b1;
    #1;
    pulses += int'(ir_write);
    tick;
    mem_ready = 1'b0;
    pulses += int'(ir_write);
    total++;
    if (pulses != 1) begin bad++; $display("[TB] FAIL lw_ir_pulses: got %0d want 1", pulses); end
    tick;
    total++;
    if ({alu_src_a, alu_src_b, immediate_control, alu_control} !== {2'b10, 2'b01, 3'b000, 4'b0000}) begin
      bad++; $display("[TB] FAIL lw_mem_adr: got %b want 10010000000",
        {alu_src_a, alu_src_b, immediate_control, alu_control});
    end
    tick;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({mem_req, mem_write, adr_src, reg_write, mem_width} !== 7'b1010010) begin
        bad++; $display("[TB] FAIL lw_read_wait%0d: got %b want 1010010",
          i, {mem_req, mem_write, adr_src, reg_write, mem_width});
      end
      tick;
    end
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    total++;
    if ({reg_write, instr_retired, result_src, mem_req} !== 5'b11010) begin
      bad++; $display("[TB] FAIL lw_mem_wb: got %b want 11010", {reg_write, instr_retired, result_src, mem_req});
    end
    tick;
  endtask

  task automatic test_store_and_reset;
    instruction = 32'h0020A223;
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    tick;
    total++;
    if (immediate_control !== 3'b001) begin
      bad++; $display("[TB] FAIL sw_imm: got %b want 001", immediate_control);
    end
    tick;
    total++;
    if ({mem_req, mem_write, adr_src, mem_width, instr_retired} !== 7'b1110100) begin
      bad++; $display("[TB] FAIL sw_write: got %b want 1110100", {mem_req, mem_write, adr_src, mem_width, instr_retired});
    end
    mem_ready = 1'b1;
    #1;
    total++;
    if (instr_retired !== 1'b1) begin bad++; $display("[TB] FAIL sw_retire: got %b want 1", instr_retired); end
    tick;
    mem_ready = 1'b0;
    total++;
    if ({mem_req, mem_write, instr_retired} !== 3'b100) begin
      bad++; $display("[TB] FAIL sw_refetch: got %b want 100", {mem_req, mem_write, instr_retired});
    end
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    tick; tick;
    reset = 1'b1;
    #1;
    total++;
    if ({mem_req, mem_write, adr_src, instr_retired, ir_write, pc_write, reg_write} !== 7'b0) begin
      bad++; $display("[TB] FAIL reset_in_write: got %b want 0000000",
        {mem_req, mem_write, adr_src, instr_retired, ir_write, pc_write, reg_write});
    end
    tick;
    reset = 1'b0;
    tick;
    total++;
    if ({mem_req, mem_write, adr_src, mem_width} !== 6'b100000) begin
      bad++; $display("[TB] FAIL after_reset_fetch: got %b want 100000", {mem_req, mem_write, adr_src, mem_width});
    end
  endtask

  task automatic test_branch;
    logic [31:0] tbl_instr [5] = '{32'h00208063, 32'h00209063, 32'h0020C063, 32'h0020F063, 32'h00208063};
    logic [2:0]  tbl_flags [5] = '{3'b100, 3'b100, 3'b010, 3'b001, 3'b000};
    logic        tbl_taken [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      instruction = tbl_instr[i];
      {equal, less_than, less_than_unsigned} = tbl_flags[i];
      mem_ready = 1'b1;
      tick;
      mem_ready = 1'b0;
      total++;
      if (immediate_control !== 3'b010) begin
        bad++; $display("[TB] FAIL br%0d_decode_imm: got %b want 010", i, immediate_control);
      end
      tick;
      total++;
      if ({pc_write, instr_retired, result_src} !== {tbl_taken[i], 3'b100}) begin
        bad++; $display("[TB] FAIL br%0d_branch: got %b want %b", i, {pc_write, instr_retired, result_src}, {tbl_taken[i], 3'b100});
      end
      tick;
      total++;
      if ({mem_req, instr_retired} !== 2'b10) begin
        bad++; $display("[TB] FAIL br%0d_refetch: got %b want 10", i, {mem_req, instr_retired});
      end
    end
    {equal, less_than, less_than_unsigned} = 3'b000;
  endtask

  task automatic test_jumps;
    instruction = 32'h000000EF;
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    tick;
    total++;
    if ({pc_write, alu_src_a, alu_src_b, result_src, reg_write, alu_control} !== {1'b1, 2'b01, 2'b10, 2'b00, 1'b0, 4'b0000}) begin
      bad++; $display("[TB] FAIL jal_state: got %b want 101100000000",
        {pc_write, alu_src_a, alu_src_b, result_src, reg_write, alu_control});
    end
    tick;
    total++;
    if ({reg_write, instr_retired, pc_write} !== 3'b110) begin
      bad++; $display("[TB] FAIL jal_wb: got %b want 110", {reg_write, instr_retired, pc_write});
    end
    tick;
    instruction = 32'h000100E7;
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    tick;
    total++;
    if ({alu_src_a, alu_src_b, immediate_control, pc_write} !== {2'b10, 2'b01, 3'b000, 1'b0}) begin
      bad++; $display("[TB] FAIL jalr_adr: got %b want 10010000", {alu_src_a, alu_src_b, immediate_control, pc_write});
    end
    tick;
    total++;
    if (pc_write !== 1'b1) begin bad++; $display("[TB] FAIL jalr_jal: got %b want 1", pc_write); end
    tick; tick;
    instruction = 32'h123450B7;
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    tick;
    total++;
    if ({alu_src_a, alu_src_b, immediate_control, reg_write} !== {2'b11, 2'b01, 3'b011, 1'b0}) begin
      bad++; $display("[TB] FAIL lui_state: got %b want 11010110", {alu_src_a, alu_src_b, immediate_control, reg_write});
    end
    tick;
    total++;
    if ({reg_write, instr_retired} !== 2'b11) begin
      bad++; $display("[TB] FAIL lui_wb: got %b want 11", {reg_write, instr_retired});
    end
    tick;
  endtask

  task automatic test_illegal;
    do_reset;
    instruction = 32'h00000000;
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    total++;
    if ({instr_retired_n, instr_retired} !== 2'b10) begin
      bad++; $display("[TB] FAIL illegal_decode_retire: got %b want 10", {instr_retired_n, instr_retired});
    end
    tick;
    total++;
    if ({trap, trap_cause, mem_req} !== 4'b1010) begin
      bad++; $display("[TB] FAIL illegal_trap: got %b want 1010", {trap, trap_cause, mem_req});
    end
    total++;
    if ({trap_n, mem_req_n, instr_retired_n} !== 3'b010) begin
      bad++; $display("[TB] FAIL illegal_nop_fetch: got %b want 010", {trap_n, mem_req_n, instr_retired_n});
    end
    mem_ready = 1'b1;
    tick; tick; tick;
    total++;
    if ({trap, trap_cause, mem_req, ir_write, pc_write, instr_retired} !== 7'b1010000) begin
      bad++; $display("[TB] FAIL trap_sticky: got %b want 1010000",
        {trap, trap_cause, mem_req, ir_write, pc_write, instr_retired});
    end
    do_reset;
    total++;
    if ({trap, trap_cause} !== 3'b000) begin
      bad++; $display("[TB] FAIL trap_cleared: got %b want 000", {trap, trap_cause});
    end
    instruction = 32'h0020A063;
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    tick;
    total++;
    if ({trap, trap_cause} !== 3'b101) begin
      bad++; $display("[TB] FAIL illegal_branch_f3: got %b want 101", {trap, trap_cause});
    end
  endtask

  task automatic test_timeout;
    do_reset;
    instruction = 32'h002081B3;
    repeat (15) tick;
    total++;
    if ({trap, mem_req} !== 2'b01) begin
      bad++; $display("[TB] FAIL timeout_early: got %b want 01", {trap, mem_req});
    end
    tick;
    total++;
    if ({trap, trap_cause, mem_req} !== 4'b1100) begin
      bad++; $display("[TB] FAIL timeout_trap: got %b want 1100", {trap, trap_cause, mem_req});
    end
    do_reset;
    repeat (15) tick;
    mem_ready = 1'b1;
    #1;
    total++;
    if (ir_write !== 1'b1) begin bad++; $display("[TB] FAIL timeout_race_ir: got %b want 1", ir_write); end
    tick;
    mem_ready = 1'b0;
    total++;
    if ({trap, trap_cause, alu_src_a} !== 5'b00001) begin
      bad++; $display("[TB] FAIL timeout_race_decode: got %b want 00001", {trap, trap_cause, alu_src_a});
    end
    do_reset;
  endtask

  initial begin
    test_reset;
    test_alu_ops;
    test_load;
    test_store_and_reset;
    test_branch;
    test_jumps;
    test_illegal;
    test_timeout;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL sim_time_limit: got expired want finished");
    $fatal(1, "[TB] time limit");
  end

endmodule
